square_wave_meter: RTL and testbench

Measures the period of an incoming square wave, counted in `clk` cycles, and reports it through a valid/ready output. It is the receive-side counterpart of the square-wave generator. It sits after any generator output or external tone input, so the sound path can recover and check the frequency-control value that produced a tone. Typical uses are loopback self-test and pitch tracking.

---
 rtl/square_wave_meter.sv | 167 ++++++++++++++++
 tb/tb_square_wave_meter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_meter.sv
// square_wave_meter: measures the period of a square wave on sq_in's MSB,
// counted in clk cycles from one rising edge to the next, and presents each
// measurement through a valid/ready output with sticky overrun and timeout
// flags.
// Optional build macro: SQUARE_WAVE_METER_AVG_EN -- present the truncated
// mean of every four consecutive captures instead of every capture.
module square_wave_meter #(
  parameter int resolution_bits = 8,
  parameter int counter_width   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [resolution_bits-1:0] sq_in,
  output logic [counter_width-1:0]   period_out,
  output logic                       period_valid,
  input  logic                       period_ready,
  output logic                       overrun,
  output logic                       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam logic [counter_width-1:0] CNT_MAX  = {counter_width{1'b1}};
  localparam logic [counter_width-1:0] CNT_ZERO = {counter_width{1'b0}};
  localparam logic [counter_width-1:0] CNT_ONE  = {{(counter_width-1){1'b0}}, 1'b1};

  // Synchronizer and edge-history flops.
  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Measurement state.
  state_t                   state_r;
  logic [counter_width-1:0] cnt_r;
  logic                     timeout_r;

  // Output register set.
  logic [counter_width-1:0] period_out_r;
  logic                     period_valid_r;
  logic                     overrun_r;

  // Decoded events.
  logic                     rise_s;
  logic                     capture_s;
  logic                     timeout_evt_s;
  logic                     accept_s;
  logic                     load_s;
  logic [counter_width-1:0] load_val_s;

  // Only the MSB carries the level; the lower sample bits are intentionally ignored.
  logic sq_unused_s;
  assign sq_unused_s = ^sq_in;

  assign rise_s        = s2_r & ~s3_r;
  assign capture_s     = (state_r == ST_MEASURE) & rise_s;
  assign timeout_evt_s = (state_r == ST_MEASURE) & ~rise_s & (cnt_r == CNT_MAX);
  assign accept_s      = period_valid_r & period_ready;

`ifdef SQUARE_WAVE_METER_AVG_EN
  // Four-capture averaging: the fourth capture presents (sum of four) >> 2.
  logic [counter_width+1:0] sum_r;
  logic [1:0]               avg_cnt_r;
  logic [counter_width+1:0] sum_next_s;

  assign sum_next_s = sum_r + {2'b00, cnt_r};
  assign load_s     = capture_s & (avg_cnt_r == 2'd3);
  assign load_val_s = sum_next_s[counter_width+1:2];

  // Accumulate captures; a timeout discards any partial group.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r     <= {(counter_width+2){1'b0}};
      avg_cnt_r <= 2'd0;
    end else if (timeout_evt_s) begin
      sum_r     <= {(counter_width+2){1'b0}};
      avg_cnt_r <= 2'd0;
    end else if (capture_s) begin
      if (avg_cnt_r == 2'd3) begin
        sum_r     <= {(counter_width+2){1'b0}};
        avg_cnt_r <= 2'd0;
      end else begin
        sum_r     <= sum_next_s;
        avg_cnt_r <= avg_cnt_r + 2'd1;
      end
    end
  end
`else
  assign load_s     = capture_s;
  assign load_val_s = cnt_r;
`endif

  // Two-flop synchronizer for the asynchronous level, plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sq_in[resolution_bits-1];
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Period FSM: IDLE waits for the first edge, MEASURE counts between edges and saturates into timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            cnt_r     <= CNT_ONE;
            timeout_r <= 1'b0;
            state_r   <= ST_MEASURE;
          end else begin
            cnt_r     <= CNT_ZERO;
          end
        end
        ST_MEASURE: begin
          if (rise_s) begin
            cnt_r     <= CNT_ONE;
          end else if (cnt_r == CNT_MAX) begin
            cnt_r     <= CNT_ZERO;
            timeout_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            cnt_r     <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= CNT_ZERO;
          timeout_r <= 1'b0;
        end
      endcase
    end
  end

  // Output handshake: a load wins over an accept; loading onto an unaccepted value flags overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_out_r   <= CNT_ZERO;
      period_valid_r <= 1'b0;
      overrun_r      <= 1'b0;
    end else if (load_s) begin
      period_out_r   <= load_val_s;
      period_valid_r <= 1'b1;
      if (period_valid_r & ~period_ready) begin
        overrun_r <= 1'b1;
      end
    end else if (accept_s) begin
      period_valid_r <= 1'b0;
    end
  end

  assign period_out   = period_out_r;
  assign period_valid = period_valid_r;
  assign overrun      = overrun_r;
  assign timeout      = timeout_r;

endmodule

// File: tb/tb_square_wave_meter.sv
// Directed testbench for square_wave_meter (counter_width = 8 so the
// timeout path is reachable in a few hundred cycles).
module tb_square_wave_meter;

  localparam int RB = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [RB-1:0] sq_in;
  logic [CW-1:0] period_out;
  logic          period_valid;
  logic          period_ready;
  logic          overrun;
  logic          timeout;

  int            checks = 0;
  int            errors = 0;
  int            valid_pulses = 0;
  logic [CW-1:0] last_val = '0;

  square_wave_meter #(
    .resolution_bits(RB),
    .counter_width(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sq_in(sq_in),
    .period_out(period_out),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .overrun(overrun),
    .timeout(timeout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; observe 1 ns after the edge and record valid cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (period_valid) begin
      valid_pulses++;
      last_val = period_out;
    end
  endtask

  task automatic set_level(input logic lv);
    sq_in = {lv, {(RB-1){1'b0}}};
  endtask

  task automatic wave(input int h, input int l);
    set_level(1'b1);
    repeat (h) tick();
    set_level(1'b0);
    repeat (l) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_level(1'b0);
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    period_ready = 1'b0;
    set_level(1'b0);
    repeat (2) tick();
    check("rst_period_out", period_out, 0);
    check("rst_valid", period_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    repeat (3) tick();

`ifdef SQUARE_WAVE_METER_AVG_EN
    // Periods 10, 11, 12, 14 -> one output of 47 >> 2 = 11.
    period_ready = 1'b1;
    valid_pulses = 0;
    wave(5, 5);
    wave(5, 6);
    wave(6, 6);
    wave(7, 7);
    check("avg_no_early_out", valid_pulses, 0);
    wave(3, 3);
    check("avg_one_out", valid_pulses, 1);
    check("avg_value", last_val, 11);
    check("avg_overrun", overrun, 0);
`else
    // 5 high / 5 low with ready held high: 1-cycle pulse of 10 per edge after the first.
    period_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      set_level(1'b1);
      for (int k = 1; k <= 5; k++) begin
        tick();
        check($sformatf("t1_valid_p%0d_h%0d", p, k), period_valid, (k == 3 && p > 0) ? 1 : 0);
        if (k == 3 && p > 0) check($sformatf("t1_period_p%0d", p), period_out, 10);
      end
      set_level(1'b0);
      for (int k = 1; k <= 5; k++) begin
        tick();
        check($sformatf("t1_valid_p%0d_l%0d", p, k), period_valid, 0);
      end
    end

    // Two captures (10 then 12) with no consumer -> overrun.
    do_reset();
    period_ready = 1'b0;
    wave(5, 5);
    wave(5, 7);
    set_level(1'b1);
    repeat (3) tick();
    check("t2_period", period_out, 12);
    check("t2_valid", period_valid, 1);
    check("t2_overrun", overrun, 1);
    period_ready = 1'b1;
    tick();
    period_ready = 1'b0;
    check("t2_valid_after_accept", period_valid, 0);
    check("t2_overrun_sticky", overrun, 1);
    check("t2_period_held", period_out, 12);
    repeat (2) tick();
    set_level(1'b0);
    repeat (4) tick();

    // Capture coinciding with an accept: new value, valid stays, no overrun.
    do_reset();
    period_ready = 1'b0;
    wave(5, 5);
    wave(4, 4);
    check("t3_pre_valid", period_valid, 1);
    check("t3_pre_period", period_out, 10);
    set_level(1'b1);
    repeat (2) tick();
    period_ready = 1'b1;
    tick();
    period_ready = 1'b0;
    check("t3_period", period_out, 8);
    check("t3_valid", period_valid, 1);
    check("t3_overrun", overrun, 0);
    set_level(1'b0);
    repeat (4) tick();

    // Reset with cnt = 7 and a pending measurement.
    do_reset();
    period_ready = 1'b0;
    wave(5, 5);
    set_level(1'b1);
    repeat (5) tick();
    set_level(1'b0);
    repeat (4) tick();
    check("t4_pre_valid", period_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_period_out", period_out, 0);
    check("t4_valid", period_valid, 0);
    check("t4_overrun", overrun, 0);
    check("t4_timeout", timeout, 0);
    period_ready = 1'b1;
    valid_pulses = 0;
    wave(5, 5);
    check("t4_first_edge_silent", valid_pulses, 0);
    wave(5, 5);
    check("t4_second_edge_out", valid_pulses, 1);
    check("t4_second_value", last_val, 10);

    // Timeout after 255 counted cycles, then recovery with P = 20.
    do_reset();
    period_ready = 1'b1;
    set_level(1'b1);
    repeat (5) tick();
    set_level(1'b0);
    n = 0;
    while (!timeout && n < 400) begin
      tick();
      n++;
    end
    check("t5_timeout_cycles", n, 253);
    check("t5_timeout", timeout, 1);
    valid_pulses = 0;
    set_level(1'b1);
    repeat (2) tick();
    check("t5_timeout_held", timeout, 1);
    tick();
    check("t5_timeout_cleared", timeout, 0);
    repeat (7) tick();
    set_level(1'b0);
    repeat (10) tick();
    check("t5_no_out_first_edge", valid_pulses, 0);
    set_level(1'b1);
    repeat (3) tick();
    check("t5_valid", period_valid, 1);
    check("t5_period", period_out, 20);
    set_level(1'b0);
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
